// File: rtl/present80_key_schedule_pkg.sv
// Shared widths, FSM encoding and S-box tables for the PRESENT-80 key schedule.
// Constants only: no latency, no flow control.
package present_pkg;

  localparam int KEY_W      = 80;
  localparam int BLK_W      = 64;
  localparam int NUM_ROUNDS = 31;
  localparam int IDX_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL
  } ks_state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

endpackage

// File: rtl/present80_key_schedule_if.sv
// Controller-side bundle for the key schedule; dir only exists with PRESENT_KS_INV_EN.
// Wires only: no latency, no flow control.
interface present80_key_schedule_if;

  logic                           load;
  logic [present_pkg::KEY_W-1:0]  key_in;
  logic                           advance;
`ifdef PRESENT_KS_INV_EN
  logic                           dir;
`endif
  logic [present_pkg::BLK_W-1:0]  round_key;
  logic [present_pkg::IDX_W-1:0]  round_idx;
  logic                           key_valid;
  logic                           last;

`ifdef PRESENT_KS_INV_EN
  modport master (output load, key_in, advance, dir,
                  input  round_key, round_idx, key_valid, last);
  modport slave  (input  load, key_in, advance, dir,
                  output round_key, round_idx, key_valid, last);
`else
  modport master (output load, key_in, advance,
                  input  round_key, round_idx, key_valid, last);
  modport slave  (input  load, key_in, advance,
                  output round_key, round_idx, key_valid, last);
`endif

endinterface

// File: rtl/present_inv_sbox.sv
// 4-bit PRESENT inverse S-box, used when walking the schedule backward.
// Purely combinational, no flow control.
module present_inv_sbox
  import present_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/sBoxLayer.sv
// 4-bit PRESENT forward S-box.
// Purely combinational, no flow control.
module sBoxLayer
  import present_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/present80_key_schedule.sv
// PRESENT-80 round-key register, stepped once per advance; PRESENT_KS_INV_EN adds backward stepping.
// 1-cycle load/advance latency; never stalls, advance is ignored where the schedule cannot move.
module present80_key_schedule
  import present_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  present80_key_schedule_if.slave ks
);

  ks_state_e        state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] rot_fwd, key_fwd;
  logic [3:0]       sbox_out;
  logic             step_bwd;

  assign rot_fwd = {key_q[18:0], key_q[79:19]};

  sBoxLayer u_sbox (
    .din  (rot_fwd[79:76]),
    .dout (sbox_out)
  );

  // Round counter folded in is the index of the key being left behind.
  assign key_fwd = {sbox_out, rot_fwd[75:20], rot_fwd[19:15] ^ idx_q[4:0], rot_fwd[14:0]};

`ifdef PRESENT_KS_INV_EN
  logic [IDX_W-1:0] idx_m1;
  logic [3:0]       inv_out;
  logic [KEY_W-1:0] key_unmix, key_bwd;

  assign idx_m1 = idx_q - 6'd1;

  present_inv_sbox u_inv_sbox (
    .din  (key_q[79:76]),
    .dout (inv_out)
  );

  assign key_unmix = {inv_out, key_q[75:20], key_q[19:15] ^ idx_m1[4:0], key_q[14:0]};
  assign key_bwd   = {key_unmix[60:0], key_unmix[79:61]};
  assign step_bwd  = ks.dir;
`else
  assign step_bwd  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    if (ks.load) begin
      state_d = RUN;
      idx_d   = 6'd1;
      key_d   = ks.key_in;
    end else if (ks.advance) begin
      unique case (state_q)
        RUN: begin
          if (!step_bwd) begin
            key_d = key_fwd;
            idx_d = idx_q + 6'd1;
            if (idx_q == 6'(NUM_ROUNDS)) state_d = FINAL;
          end
`ifdef PRESENT_KS_INV_EN
          else if (idx_q != 6'd1) begin
            key_d = key_bwd;
            idx_d = idx_m1;
          end
`endif
        end
        FINAL: begin
`ifdef PRESENT_KS_INV_EN
          if (step_bwd) begin
            key_d   = key_bwd;
            idx_d   = idx_m1;
            state_d = RUN;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
    end
  end

  assign ks.round_key = key_q[KEY_W-1:KEY_W-BLK_W];
  assign ks.round_idx = idx_q;
  assign ks.key_valid = (state_q != IDLE);
  assign ks.last      = (state_q == FINAL);

endmodule
